gbt_cnt_pattern_checker: RTL and testbench
==========================================

// Module: gbt_cnt_pattern_checker
// PURPOSE
//  Receive-side checker for the GBT link counter test pattern: the TX end sends {cnt,cnt} on motor_data_b64,
//  with cnt incrementing by 1 each frame clock and held at 0 while SFP LOS is asserted.
//  Sits on the GBT RX frame-clock side and compares each received 64b frame against the expected value.
//  Reports lock status, error pulses, and saturating error/frame counters for diag pins, LEDs and the PS.
// PARAMETERS
//  LOCK_CNT    16  consecutive good frames in LOCKING needed to enter LOCKED (>=1)
//  UNLOCK_ERR  4   consecutive bad frames in LOCKED needed to drop to UNLOCKED (>=1)
//  CNT_W       32  width of err_cnt_o and frame_cnt_o
// PORTS
//  ClkRs_ix      input   ckrs_t  .clk = single clock, the GBT RX frame clock; .reset = synchronous, active-high reset
//  los_i         input   1       SFP loss of signal; synchronous to ClkRs_ix.clk
//  valid_i       input   1       frame valid (link ready and RX header locked)
//  data_i        input   64      received motor_data_b64
//  clear_i       input   1       1-cycle pulse; clears err_cnt_o and frame_cnt_o
//  locked_o      output  1       checker is in LOCKED
//  error_o       output  1       1-cycle pulse per mismatching frame while LOCKED
//  err_cnt_o     output  CNT_W   saturating count of error_o pulses
//  frame_cnt_o   output  CNT_W   saturating count of frames checked while LOCKED
//  state_o       output  2       current state (t_pchk_state), for diag
// BEHAVIOUR
//  All outputs are registered. Reset values: all outputs 0, state_o = UNLOCKED, internal expected value = 0.
//  Latency: the frame presented at cycle N is reflected in error_o, counters and state at cycle N+1.
//  Good frame: data_i[63:32] == data_i[31:0] AND data_i[31:0] == expected.
//    The second condition does not apply to the seed frame.
//  Expected value: after every valid frame, expected <= expected + 1 (mod 2^32).
//    Expected advances from the expected value, not the received one, so one corrupted frame gives one error.
//    32-bit wrap FFFF_FFFF -> 0000_0000 is a good transition.
//  States:
//    UNLOCKED: on valid_i with halves equal -> seed expected = data_i[31:0] + 1, good_cnt = 1.
//      If LOCK_CNT == 1, go to LOCKED; otherwise go to LOCKING. Frames with unequal halves are ignored.
//    LOCKING: good frame -> good_cnt++. When good_cnt reaches LOCK_CNT -> LOCKED.
//      Bad frame -> UNLOCKED. No error_o and no counting in this state.
//    LOCKED: every valid frame -> frame_cnt_o++.
//      Bad frame -> error_o = 1, err_cnt_o++, bad_cnt++. Good frame -> bad_cnt = 0.
//      When bad_cnt reaches UNLOCK_ERR -> UNLOCKED.
//  valid_i low: no compare and no expected advance. In LOCKING or LOCKED it forces UNLOCKED (frames were lost).
//  los_i high: forces UNLOCKED at the next edge and suppresses error_o. Counters hold their values.
//  Priority: reset > los_i > valid_i low > compare.
//  clear_i: counters go to 0 at the next edge. If clear_i and an increment fall in the same cycle, the result is 0.
//    State is unaffected.
//  Saturation: counters stick at all-ones and never wrap.
//  Reset mid-operation: immediate return to reset values at the next edge, whatever the state.
// STRUCTURE
//  MCPkg: typedef enum logic [1:0] {UNLOCKED, LOCKING, LOCKED} t_pchk_state.
//  MCPkg: typedef struct {locked, error, err_cnt, frame_cnt} t_pchk_status, for diag plumbing.
//  Sub-module sat_counter #(W): synchronous clear, enable and saturate.
//    Instantiated twice, once for err_cnt_o and once for frame_cnt_o.
//  The FSM, expected-value register, good_cnt and bad_cnt live in this module.
//  Lock and unlock counter widths are $clog2(LOCK_CNT+1) and $clog2(UNLOCK_ERR+1).
// TESTING
//  1 Lock: after reset, drive {k,k} with k = 0..19, valid_i = 1.
//    -> locked_o rises 1 cycle after the 16th frame. err_cnt_o = 0. frame_cnt_o = 4 after the last frame.
//  2 Single error: while locked, replace one frame with {5,5}.
//    -> error_o pulses once, err_cnt_o = 1, locked_o stays 1, the next frames are good.
//  3 Half mismatch and unlock: while locked, send {A,A+1} four times in a row.
//    -> 4 error_o pulses. locked_o = 0 after the 4th.
//  4 Wrap: seed at FFFF_FFF0 and run 40 frames across the wrap.
//    -> locked, err_cnt_o = 0.
//  5 LOS/valid: assert los_i for 3 cycles while locked.
//    -> UNLOCKED next cycle, no error_o, counters held.
//    -> After los_i drops, the TX counter restarts at 0 and the checker relocks after 16 frames.
//    -> Repeat with valid_i low for 1 cycle: same behaviour.
//  6 Saturation, clear, reset: use CNT_W = 4 and inject 20 errors while locked.
//    -> err_cnt_o = 4'hF.
//    -> clear_i coinciding with an error -> 0.
//    -> Reset asserted mid-LOCKING -> all outputs 0 next cycle.

Source files
------------

// File: rtl/gbt_cnt_pattern_checker_pkg.sv
// Shared types for the GBT counter-pattern checker.
// State encoding, clock/reset bundle and diag status record.
package gbt_cnt_pattern_checker_pkg;

    localparam int DATA_W = 64;
    localparam int HALF_W = 32;
    localparam int DIAG_CNT_W = 32;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2
    } t_pchk_state;

    typedef struct packed {
        logic clk;
        logic reset;
    } ckrs_t;

    typedef struct packed {
        logic                  locked;
        logic                  error;
        logic [DIAG_CNT_W-1:0] err_cnt;
        logic [DIAG_CNT_W-1:0] frame_cnt;
    } t_pchk_status;

    function automatic logic halves_equal(
        input logic [DATA_W-1:0] d
    );
        return d[DATA_W-1:HALF_W] == d[HALF_W-1:0];
    endfunction

endpackage

// File: rtl/gbt_cnt_pattern_checker_if.sv
// Frame input / status output bundle of the counter-pattern checker.
// The master side feeds frames, the slave side is the checker.
interface gbt_cnt_pattern_checker_if #(
    parameter int CNT_W = 32
);
    import gbt_cnt_pattern_checker_pkg::*;

    logic              los_i;
    logic              valid_i;
    logic [63:0]       data_i;
    logic              clear_i;
    logic              locked_o;
    logic              error_o;
    logic [CNT_W-1:0]  err_cnt_o;
    logic [CNT_W-1:0]  frame_cnt_o;
    t_pchk_state       state_o;

    modport master (
        output los_i,
        output valid_i,
        output data_i,
        output clear_i,
        input  locked_o,
        input  error_o,
        input  err_cnt_o,
        input  frame_cnt_o,
        input  state_o
    );

    modport slave (
        input  los_i,
        input  valid_i,
        input  data_i,
        input  clear_i,
        output locked_o,
        output error_o,
        output err_cnt_o,
        output frame_cnt_o,
        output state_o
    );

endinterface

// File: rtl/gbt_cnt_pattern_checker_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
// Clear wins over a same-cycle increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/gbt_cnt_pattern_checker.sv
// Receive-side checker for the GBT {cnt,cnt} link test pattern.
// Tracks lock, flags mismatching frames and counts errors/frames.
module gbt_cnt_pattern_checker
    import gbt_cnt_pattern_checker_pkg::*;
#(
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_ERR = 4,
    parameter int CNT_W      = 32
) (
    input  ckrs_t                      ClkRs_ix,
    gbt_cnt_pattern_checker_if.slave   bus
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_ERR + 1);
    localparam logic [GW-1:0] LOCK_V = GW'(LOCK_CNT);
    localparam logic [BW-1:0] UNLOCK_V = BW'(UNLOCK_ERR);

    logic clk;
    logic rst;

    assign clk = ClkRs_ix.clk;
    assign rst = ClkRs_ix.reset;

    t_pchk_state   state_q;
    t_pchk_state   state_d;
    logic [31:0]   exp_q;
    logic [31:0]   exp_d;
    logic [GW-1:0] good_q;
    logic [GW-1:0] good_d;
    logic [BW-1:0] bad_q;
    logic [BW-1:0] bad_d;
    logic          err_d;
    logic          frm_en;
    logic          locked_q;
    logic          err_q;
    logic [31:0]   lo;
    logic          halves_eq;
    logic          match;

    assign lo        = bus.data_i[31:0];
    assign halves_eq = halves_equal(bus.data_i);
    assign match     = halves_eq && (lo == exp_q);

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        good_d  = good_q;
        bad_d   = bad_q;
        err_d   = 1'b0;
        frm_en  = 1'b0;
        if (bus.los_i) begin
            state_d = UNLOCKED;
        end else if (!bus.valid_i) begin
            // a missing frame means the sequence can no longer be trusted
            state_d = UNLOCKED;
        end else begin
            unique case (state_q)
                UNLOCKED: begin
                    if (halves_eq) begin
                        exp_d  = lo + 32'd1;
                        good_d = GW'(1);
                        if (LOCK_CNT == 1) begin
                            state_d = LOCKED;
                        end else begin
                            state_d = LOCKING;
                        end
                    end
                end
                LOCKING: begin
                    exp_d = exp_q + 32'd1;
                    if (match) begin
                        good_d = good_q + GW'(1);
                        if (good_d == LOCK_V) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        state_d = UNLOCKED;
                    end
                end
                LOCKED: begin
                    exp_d  = exp_q + 32'd1;
                    frm_en = 1'b1;
                    if (match) begin
                        bad_d = '0;
                    end else begin
                        err_d = 1'b1;
                        bad_d = bad_q + BW'(1);
                        if (bad_d == UNLOCK_V) begin
                            state_d = UNLOCKED;
                        end
                    end
                end
                default: begin
                    state_d = UNLOCKED;
                end
            endcase
        end
        if (state_d != LOCKED) begin
            bad_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= UNLOCKED;
            exp_q    <= '0;
            good_q   <= '0;
            bad_q    <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
            locked_q <= (state_d == LOCKED);
            err_q    <= err_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.clear_i),
        .en  (err_d),
        .q   (bus.err_cnt_o)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_frame_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.clear_i),
        .en  (frm_en),
        .q   (bus.frame_cnt_o)
    );

    assign bus.locked_o = locked_q;
    assign bus.error_o  = err_q;
    assign bus.state_o  = state_q;

endmodule

// File: tb/tb_gbt_cnt_pattern_checker.sv
// Scoreboard bench for the GBT counter-pattern checker.
// Driver feeds a reference model; a monitor compares every cycle.
module tb_gbt_cnt_pattern_checker;
    import gbt_cnt_pattern_checker_pkg::*;

    localparam int LOCK_CNT   = 16;
    localparam int UNLOCK_ERR = 4;
    localparam int CNT_W      = 4;
    localparam int MAXC       = (1 << CNT_W) - 1;

    typedef struct packed {
        logic             locked;
        logic             error;
        logic [CNT_W-1:0] err_cnt;
        logic [CNT_W-1:0] frm_cnt;
        logic [1:0]       st;
    } exp_t;

    logic  clk;
    logic  rst;
    ckrs_t ck;

    assign ck = '{clk: clk, reset: rst};

    gbt_cnt_pattern_checker_if #(.CNT_W(CNT_W)) bus ();

    gbt_cnt_pattern_checker #(
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_ERR (UNLOCK_ERR),
        .CNT_W      (CNT_W)
    ) dut (
        .ClkRs_ix (ck),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    exp_t sbq[$];

    // reference model: 0 = unlocked, 1 = locking, 2 = locked
    int          m_st;
    int unsigned m_exp;
    int          m_good;
    int          m_bad;
    int          m_err;
    int          m_frm;
    logic [31:0] tx;

    task automatic model(input bit r, input bit l, input bit v,
                         input bit c, input logic [63:0] d);
        bit e;
        bit fi;
        bit ok;
        int unsigned hi;
        int unsigned lo;
        exp_t x;
        e  = 0;
        fi = 0;
        hi = d[63:32];
        lo = d[31:0];
        if (r) begin
            m_st = 0; m_exp = 0; m_good = 0;
            m_bad = 0; m_err = 0; m_frm = 0;
        end else begin
            if (l || !v) begin
                m_st = 0;
            end else if (m_st == 0) begin
                if (hi == lo) begin
                    m_exp  = lo + 1;
                    m_good = 1;
                    m_bad  = 0;
                    m_st   = (LOCK_CNT == 1) ? 2 : 1;
                end
            end else begin
                ok = (hi == lo) && (lo == m_exp);
                m_exp = m_exp + 1;
                if (m_st == 1) begin
                    if (!ok) m_st = 0;
                    else begin
                        m_good++;
                        if (m_good >= LOCK_CNT) begin
                            m_st = 2;
                            m_bad = 0;
                        end
                    end
                end else begin
                    fi = 1;
                    if (ok) m_bad = 0;
                    else begin
                        e = 1;
                        m_bad++;
                        if (m_bad >= UNLOCK_ERR) m_st = 0;
                    end
                end
            end
            if (c) begin
                m_err = 0;
                m_frm = 0;
            end else begin
                if (e && m_err < MAXC) m_err++;
                if (fi && m_frm < MAXC) m_frm++;
            end
        end
        x.locked  = (m_st == 2);
        x.error   = e;
        x.err_cnt = CNT_W'(m_err);
        x.frm_cnt = CNT_W'(m_frm);
        x.st      = 2'(m_st);
        sbq.push_back(x);
    endtask

    task automatic step(input bit r, input bit l, input bit v,
                        input bit c, input logic [63:0] d);
        @(negedge clk);
        rst         = r;
        bus.los_i   = l;
        bus.valid_i = v;
        bus.clear_i = c;
        bus.data_i  = d;
        model(r, l, v, c, d);
    endtask

    task automatic good_frame();
        step(0, 0, 1, 0, {tx, tx});
        tx = tx + 32'd1;
    endtask

    task automatic bad_frame(input bit c);
        step(0, 0, 1, c, {tx, ~tx});
        tx = tx + 32'd1;
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, want, $time);
        end
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                x = sbq.pop_front();
                chk("locked_o", 32'(bus.locked_o), 32'(x.locked));
                chk("error_o", 32'(bus.error_o), 32'(x.error));
                chk("err_cnt_o", 32'(bus.err_cnt_o), 32'(x.err_cnt));
                chk("frame_cnt_o", 32'(bus.frame_cnt_o), 32'(x.frm_cnt));
                chk("state_o", 32'(bus.state_o), 32'(x.st));
            end
        end
    end

    initial begin
        int p;
        bit r;
        bit l;
        bit v;
        bit c;
        bit bad;
        logic [63:0] d;
        rst = 1'b1;
        bus.los_i = 1'b0;
        bus.valid_i = 1'b0;
        bus.clear_i = 1'b0;
        bus.data_i = '0;
        tx = '0;
        m_st = 0; m_exp = 0; m_good = 0;
        m_bad = 0; m_err = 0; m_frm = 0;

        step(1, 0, 0, 0, 64'd0);
        step(1, 0, 0, 0, 64'd0);

        // lock on 0..19
        tx = '0;
        for (int k = 0; k < 20; k++) good_frame();

        // single corrupted frame {5,5}
        for (int k = 0; k < 3; k++) good_frame();
        step(0, 0, 1, 0, {32'd5, 32'd5});
        tx = tx + 32'd1;
        for (int k = 0; k < 5; k++) good_frame();

        // halves differ four times in a row -> unlock
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 1, 0, {tx, tx + 32'd1});
            tx = tx + 32'd1;
        end

        // wrap across FFFF_FFFF
        tx = 32'hFFFF_FFF0 - 32'($urandom_range(0, 8));
        for (int k = 0; k < 40; k++) good_frame();

        // LOS for 3 cycles, TX holds 0, then relock
        for (int k = 0; k < 3; k++) step(0, 1, 1, 0, 64'd0);
        tx = '0;
        for (int k = 0; k < 20; k++) good_frame();

        // valid low for 1 cycle, then relock
        step(0, 0, 0, 0, {tx, tx});
        tx = '0;
        for (int k = 0; k < 20; k++) good_frame();

        // 20 isolated errors saturate err_cnt_o
        for (int k = 0; k < 20; k++) begin
            bad_frame(0);
            good_frame();
        end
        bad_frame(1);
        for (int k = 0; k < 3; k++) good_frame();

        // reset while LOCKING
        step(0, 1, 1, 0, 64'd0);
        tx = '0;
        for (int k = 0; k < 5; k++) good_frame();
        step(1, 0, 1, 0, {tx, tx});
        tx = tx + 32'd1;
        for (int k = 0; k < 20; k++) good_frame();

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            p   = int'($urandom_range(0, 999));
            r   = (p < 5);
            l   = (p >= 5) && (p < 25);
            v   = !((p >= 25) && (p < 55));
            c   = ($urandom_range(0, 24) == 0);
            bad = ($urandom_range(0, 11) == 0);
            if (l) d = 64'd0;
            else if (bad) d = {$urandom, $urandom};
            else d = {tx, tx};
            step(r, l, v, c, d);
            if (l) tx = '0;
            else tx = tx + 32'd1;
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
